// File: rtl/uncache_axi_bridge_pkg.sv
// rtl/uncache_axi_bridge_pkg.sv - shared encodings and size helpers for the uncached AXI4-Lite bridge
package uncache_axi_bridge_pkg;

  localparam logic [1:0] UC_SIZE_B = 2'd0;
  localparam logic [1:0] UC_SIZE_H = 2'd1;
  localparam logic [1:0] UC_SIZE_W = 2'd2;
  localparam logic [1:0] UC_SIZE_D = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_WR_RESP,
    ST_RESP
  } bridge_state_e;

  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    case (size)
      UC_SIZE_B: return 8'h01;
      UC_SIZE_H: return 8'h03;
      UC_SIZE_W: return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_off_mask(input logic [1:0] size);
    case (size)
      UC_SIZE_B: return 3'd0;
      UC_SIZE_H: return 3'd1;
      UC_SIZE_W: return 3'd3;
      default:   return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uncache_lane_align.sv
// rtl/uncache_lane_align.sv - combinational byte-lane steering for requests and read responses
module uncache_lane_align
  import uncache_axi_bridge_pkg::*;
(
  input  logic [1:0]  req_size_i,
  input  logic [2:0]  req_off_i,
  input  logic [63:0] req_wdata_i,
  input  logic [1:0]  rsp_size_i,
  input  logic [2:0]  rsp_off_i,
  input  logic [63:0] rsp_rdata_i,
  output logic        misaligned_o,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [7:0]  rsp_bytes;
  logic [63:0] rsp_keep;

  always_comb begin
    misaligned_o = |(req_off_i & size_off_mask(req_size_i));
    wstrb_o      = size_byte_mask(req_size_i) << req_off_i;
    wdata_o      = req_wdata_i << {req_off_i, 3'b000};

    rsp_bytes = size_byte_mask(rsp_size_i);
    rsp_keep  = '0;
    for (int i = 0; i < 8; i++) begin
      rsp_keep[i*8 +: 8] = {8{rsp_bytes[i]}};
    end
    rdata_o = (rsp_rdata_i >> {rsp_off_i, 3'b000}) & rsp_keep;
  end

endmodule

// File: rtl/uncache_axi_bridge.sv
// rtl/uncache_axi_bridge.sv - single-outstanding LSU uncached port to AXI4-Lite master with timeout
module uncache_axi_bridge
  import uncache_axi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uncache_mem_vld_i,
  output logic        uncache_mem_ready_o,
  input  logic        uncache_mem_write_i,
  input  logic [2:0]  uncache_mem_size_i,
  input  logic [63:0] uncache_mem_addr_i,
  input  logic [63:0] uncache_mem_wdata_i,
  output logic        uncache_mem_resp_vld_o,
  input  logic        uncache_mem_resp_rdy_i,
  output logic [63:0] uncache_mem_resp_data_o,
  output logic        uncache_mem_resp_err_o,
  output logic        store_err_o,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [63:0] m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [63:0] m_araddr,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [63:0] m_rdata,
  input  logic [1:0]  m_rresp
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  bridge_state_e state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic        rready_q, rready_d, bready_q, bready_d;
  logic        resp_vld_q, resp_vld_d, resp_err_q, resp_err_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        store_err_q, store_err_d;

  logic        req_misaligned;
  logic [7:0]  req_wstrb;
  logic [63:0] req_wdata, rsp_rdata;
  logic        aw_hs, w_hs, timer_expired;
  logic        unused_size_hi;

  assign unused_size_hi = uncache_mem_size_i[2];

  uncache_lane_align u_lane_align (
    .req_size_i   (uncache_mem_size_i[1:0]),
    .req_off_i    (uncache_mem_addr_i[2:0]),
    .req_wdata_i  (uncache_mem_wdata_i),
    .rsp_size_i   (size_q),
    .rsp_off_i    (off_q),
    .rsp_rdata_i  (m_rdata),
    .misaligned_o (req_misaligned),
    .wstrb_o      (req_wstrb),
    .wdata_o      (req_wdata),
    .rdata_o      (rsp_rdata)
  );

  assign timer_expired = (cnt_q == CNT_LAST);

  // A handshake in the expiry cycle is checked first so a last-moment response still completes.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    write_d     = write_q;
    off_d       = off_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cnt_d       = cnt_q;
    arvalid_d   = arvalid_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    rready_d    = rready_q;
    bready_d    = bready_q;
    resp_vld_d  = resp_vld_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    store_err_d = 1'b0;
    aw_hs       = awvalid_q & m_awready;
    w_hs        = wvalid_q & m_wready;

    case (state_q)
      ST_IDLE: begin
        if (uncache_mem_vld_i) begin
          size_d    = uncache_mem_size_i[1:0];
          write_d   = uncache_mem_write_i;
          off_d     = uncache_mem_addr_i[2:0];
          addr_d    = {uncache_mem_addr_i[63:3], 3'b000};
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          if (req_misaligned) begin
            state_d = ST_RESP;
            if (uncache_mem_write_i) begin
              store_err_d = 1'b1;
            end else begin
              resp_vld_d  = 1'b1;
              resp_err_d  = 1'b1;
              resp_data_d = '0;
            end
          end else if (uncache_mem_write_i) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        cnt_d = cnt_q + 16'd1;
        if (arvalid_q && m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RD_DATA;
        end else if (timer_expired) begin
          arvalid_d   = 1'b0;
          resp_vld_d  = 1'b1;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RD_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (rready_q && m_rvalid) begin
          rready_d    = 1'b0;
          resp_vld_d  = 1'b1;
          resp_err_d  = (m_rresp != AXI_RESP_OKAY);
          resp_data_d = rsp_rdata;
          state_d     = ST_RESP;
        end else if (timer_expired) begin
          rready_d    = 1'b0;
          resp_vld_d  = 1'b1;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_WR: begin
        cnt_d     = cnt_q + 16'd1;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        awvalid_d = awvalid_q & ~m_awready;
        wvalid_d  = wvalid_q & ~m_wready;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_WR_RESP;
        end else if (timer_expired) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          store_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WR_RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (bready_q && m_bvalid) begin
          bready_d    = 1'b0;
          store_err_d = (m_bresp != AXI_RESP_OKAY);
          state_d     = ST_IDLE;
        end else if (timer_expired) begin
          bready_d    = 1'b0;
          store_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RESP: begin
        // A misaligned store parks here for one cycle only; it never raises resp_vld.
        if (write_q) begin
          state_d = ST_IDLE;
        end else if (uncache_mem_resp_rdy_i) begin
          resp_vld_d = 1'b0;
          resp_err_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      write_q     <= 1'b0;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cnt_q       <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      store_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      write_q     <= write_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cnt_q       <= cnt_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      resp_vld_q  <= resp_vld_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
      store_err_q <= store_err_d;
    end
  end

  assign uncache_mem_ready_o     = (state_q == ST_IDLE);
  assign uncache_mem_resp_vld_o  = resp_vld_q;
  assign uncache_mem_resp_data_o = resp_data_q;
  assign uncache_mem_resp_err_o  = resp_err_q;
  assign store_err_o             = store_err_q;
  assign m_arvalid               = arvalid_q;
  assign m_araddr                = addr_q;
  assign m_rready                = rready_q;
  assign m_awvalid               = awvalid_q;
  assign m_awaddr                = addr_q;
  assign m_wvalid                = wvalid_q;
  assign m_wdata                 = wdata_q;
  assign m_wstrb                 = wstrb_q;
  assign m_bready                = bready_q;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// tb/tb_uncache_axi_bridge.sv - scoreboard bench for uncache_axi_bridge with a configurable AXI4-Lite slave
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, ready, write, resp_vld, resp_rdy, resp_err, store_err;
  logic [2:0]  size;
  logic [63:0] addr, wdata, resp_data;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int arvalid_cycles = 0;
  int serr_cycles = 0;

  int          cfg_ar_delay = 0, cfg_aw_delay = 0, cfg_w_delay = 0;
  bit          cfg_r_hold = 1'b0;
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'd0, cfg_bresp = 2'd0;
  bit          r_pend = 1'b0;

  logic [63:0] exp_ar[$];
  logic [63:0] exp_aw[$];
  logic [71:0] exp_w[$];
  logic [64:0] exp_resp[$];
  int          exp_serr[$];

  uncache_axi_bridge #(.TIMEOUT(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .uncache_mem_vld_i       (vld),
    .uncache_mem_ready_o     (ready),
    .uncache_mem_write_i     (write),
    .uncache_mem_size_i      (size),
    .uncache_mem_addr_i      (addr),
    .uncache_mem_wdata_i     (wdata),
    .uncache_mem_resp_vld_o  (resp_vld),
    .uncache_mem_resp_rdy_i  (resp_rdy),
    .uncache_mem_resp_data_o (resp_data),
    .uncache_mem_resp_err_o  (resp_err),
    .store_err_o             (store_err),
    .m_awvalid               (m_awvalid),
    .m_awready               (m_awready),
    .m_awaddr                (m_awaddr),
    .m_wvalid                (m_wvalid),
    .m_wready                (m_wready),
    .m_wdata                 (m_wdata),
    .m_wstrb                 (m_wstrb),
    .m_bvalid                (m_bvalid),
    .m_bready                (m_bready),
    .m_bresp                 (m_bresp),
    .m_arvalid               (m_arvalid),
    .m_arready               (m_arready),
    .m_araddr                (m_araddr),
    .m_rvalid                (m_rvalid),
    .m_rready                (m_rready),
    .m_rdata                 (m_rdata),
    .m_rresp                 (m_rresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event %h required none", name, act);
  endtask

  // Slave: samples handshakes mid-cycle, updates its outputs just after the next rising edge.
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got;
    int ar_cnt, aw_cnt, w_cnt;
    m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    aw_got = 0; w_got = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge clk);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      b_hs  = m_bvalid && m_bready;
      @(posedge clk);
      #1;
      if (r_hs) m_rvalid = 0;
      if (ar_hs) r_pend = 1;
      if (r_pend && !cfg_r_hold) begin
        m_rvalid = 1; m_rdata = cfg_rdata; m_rresp = cfg_rresp; r_pend = 0;
      end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (b_hs) m_bvalid = 0;
      if (aw_got && w_got) begin
        m_bvalid = 1; m_bresp = cfg_bresp; aw_got = 0; w_got = 0;
      end
      ar_cnt = m_arvalid ? ar_cnt + 1 : 0;
      aw_cnt = m_awvalid ? aw_cnt + 1 : 0;
      w_cnt  = m_wvalid ? w_cnt + 1 : 0;
      m_arready = (ar_cnt > cfg_ar_delay);
      m_awready = (aw_cnt > cfg_aw_delay);
      m_wready  = (w_cnt > cfg_w_delay);
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer or pulses an error.
  initial begin
    logic [71:0] ew;
    logic [64:0] er;
    forever begin
      @(negedge clk);
      if (m_arvalid) arvalid_cycles++;
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) unexpected("ar_handshake", m_araddr);
        else check("araddr", m_araddr, exp_ar.pop_front());
      end
      if (m_awvalid && m_awready) begin
        if (exp_aw.size() == 0) unexpected("aw_handshake", m_awaddr);
        else check("awaddr", m_awaddr, exp_aw.pop_front());
      end
      if (m_wvalid && m_wready) begin
        if (exp_w.size() == 0) unexpected("w_handshake", m_wdata);
        else begin
          ew = exp_w.pop_front();
          check("wdata", m_wdata, ew[71:8]);
          check("wstrb", 64'(m_wstrb), 64'(ew[7:0]));
        end
      end
      if (resp_vld && resp_rdy) begin
        if (exp_resp.size() == 0) unexpected("lsu_resp", resp_data);
        else begin
          er = exp_resp.pop_front();
          check("resp_data", resp_data, er[63:0]);
          check("resp_err", 64'(resp_err), 64'(er[64]));
        end
      end
      if (store_err) begin
        serr_cycles++;
        if (exp_serr.size() == 0) unexpected("store_err", 64'(cyc));
        else check("store_err_cycle", 64'(cyc), 64'(exp_serr.pop_front()));
      end
    end
  end

  task automatic issue(input logic wr, input logic [2:0] sz, input logic [63:0] a,
                       input logic [63:0] d, output int n);
    @(posedge clk);
    #1;
    vld = 1; write = wr; size = sz; addr = a; wdata = d;
    @(negedge clk);
    n = cyc;
    check("req_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    vld = 0;
  endtask

  task automatic wait_resp(input int n, input int lat, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_vld) break;
    end
    check(name, 64'(cyc - n), 64'(lat));
  endtask

  task automatic wait_ready(input int n, input int lat, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    check(name, 64'(cyc - n), 64'(lat));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready && !resp_vld) break;
    end
  endtask

  task automatic check_idle(input string name);
    check(name, 64'({ready, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                     resp_vld, resp_err, store_err}), 64'h100);
  endtask

  initial begin
    int n;
    rst = 1; vld = 0; write = 0; size = 0; addr = 0; wdata = 0; resp_rdy = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle("reset_state");

    cfg_rdata = 64'hAABBCCDD_11223344; cfg_rresp = 2'd0;
    exp_ar.push_back(64'h1000);
    exp_resp.push_back({1'b0, 64'h00000000_AABBCCDD});
    issue(1'b0, 3'd2, 64'h1004, '0, n);
    wait_resp(n, 3, "load_word_latency");
    wait_idle();

    exp_aw.push_back(64'h2000);
    exp_w.push_back({64'h00000000_5A000000, 8'h08});
    issue(1'b1, 3'd0, 64'h2003, 64'h5A, n);
    wait_ready(n, 3, "store_byte_ready_return");
    wait_idle();

    cfg_aw_delay = 4; cfg_bresp = 2'd2; serr_cycles = 0;
    exp_aw.push_back(64'h4008);
    exp_w.push_back({64'hDEADBEEF_00000000, 8'hF0});
    issue(1'b1, 3'd2, 64'h400C, 64'hDEADBEEF, n);
    exp_serr.push_back(n + 7);
    wait_ready(n, 7, "store_late_aw_ready_return");
    repeat (3) @(negedge clk);
    check("store_err_width", 64'(serr_cycles), 64'd1);
    cfg_aw_delay = 0; cfg_bresp = 2'd0;

    arvalid_cycles = 0;
    exp_resp.push_back({1'b1, 64'h0});
    issue(1'b0, 3'd1, 64'h3001, '0, n);
    wait_resp(n, 1, "misaligned_load_latency");
    wait_idle();
    check("misaligned_load_no_ar", 64'(arvalid_cycles), 64'd0);

    issue(1'b1, 3'd2, 64'h5002, 64'h11223344, n);
    exp_serr.push_back(n + 1);
    wait_ready(n, 2, "misaligned_store_ready_return");
    wait_idle();

    cfg_rdata = 64'h88776655_44332211; cfg_rresp = 2'd3;
    exp_ar.push_back(64'h7000);
    exp_resp.push_back({1'b1, 64'h88});
    issue(1'b0, 3'd0, 64'h7007, '0, n);
    wait_resp(n, 3, "load_byte_decerr_latency");
    wait_idle();

    cfg_rresp = 2'd0;
    exp_ar.push_back(64'h7000);
    exp_resp.push_back({1'b0, 64'h4433});
    issue(1'b0, 3'd5, 64'h7002, '0, n);
    wait_resp(n, 3, "load_half_latency");
    wait_idle();

    exp_aw.push_back(64'h9000);
    exp_w.push_back({64'h01234567_89ABCDEF, 8'hFF});
    issue(1'b1, 3'd3, 64'h9000, 64'h01234567_89ABCDEF, n);
    wait_ready(n, 3, "store_double_ready_return");
    wait_idle();

    cfg_ar_delay = 255; resp_rdy = 0; arvalid_cycles = 0;
    exp_resp.push_back({1'b1, 64'h0});
    issue(1'b0, 3'd3, 64'h6000, '0, n);
    wait_resp(n, 9, "timeout_resp_latency");
    check("timeout_arvalid_cycles", 64'(arvalid_cycles), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_resp_vld", 64'(resp_vld), 64'd1);
      check("hold_resp_data", resp_data, 64'h0);
      check("hold_resp_err", 64'(resp_err), 64'd1);
    end
    @(posedge clk);
    #1 resp_rdy = 1;
    wait_idle();
    cfg_ar_delay = 0;

    cfg_r_hold = 1;
    exp_ar.push_back(64'h8000);
    issue(1'b0, 3'd2, 64'h8000, '0, n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_rready) break;
    end
    check("reached_rd_data", 64'(m_rready), 64'd1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle("reset_mid_transaction");
    repeat (4) @(negedge clk);
    cfg_r_hold = 0; r_pend = 0;

    check("ar_queue_drained", 64'(exp_ar.size()), 64'd0);
    check("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    check("w_queue_drained", 64'(exp_w.size()), 64'd0);
    check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    check("store_err_queue_drained", 64'(exp_serr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish within time limit required finish");
    $fatal(1);
  end

endmodule

// File: doc/uncache_axi_bridge.md
# uncache_axi_bridge

Bridges the load/store unit's single-outstanding uncached-memory port to an AXI4-Lite master. It lane-aligns store data and write strobes, and right-aligns load data so the LSU sees bytes in bits [7:0] upward. It also detects misaligned accesses and bus timeouts. Sits directly downstream of the LSU, between it and the SoC interconnect. One transaction is in flight at a time.

## Interface
- TIMEOUT, 256: bus-wait cycles before a transaction is abandoned; legal range 1..65535.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- uncache_mem_vld_i  in  1  request valid from LSU.
- uncache_mem_ready_o  out  1  bridge can accept a request.
- uncache_mem_write_i  in  1  1 = store, 0 = load.
- uncache_mem_size_i  in  3  [1:0] size: 0 byte, 1 half, 2 word, 3 double; bit 2 ignored.
- uncache_mem_addr_i  in  64  byte address.
- uncache_mem_wdata_i  in  64  store data, zero-extended in the low bytes.
- uncache_mem_resp_vld_o  out  1  load response valid.
- uncache_mem_resp_rdy_i  in  1  LSU accepts the response.
- uncache_mem_resp_data_o  out  64  load data, right-aligned, upper bytes zero.
- uncache_mem_resp_err_o  out  1  the load failed (misaligned, SLVERR/DECERR, or timeout).
- store_err_o  out  1  one-cycle pulse when a store fails.
- m_awvalid/m_awready/m_awaddr  out/in/out  1/1/64  write address channel.
- m_wvalid/m_wready/m_wdata/m_wstrb  out/in/out/out  1/1/64/8  write data channel.
- m_bvalid/m_bready/m_bresp  in/out/in  1/1/2  write response channel.
- m_arvalid/m_arready/m_araddr  out/in/out  1/1/64  read address channel.
- m_rvalid/m_rready/m_rdata/m_rresp  in/out/in/in  1/1/64/2  read data channel.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR (AW and W together), WR_RESP, RESP.
- A request is accepted on `uncache_mem_vld_i && uncache_mem_ready_o`. Ready is high only in IDLE.
- On accept, register the following:
  - size
  - write
  - addr[2:0]
  - aligned address: addr with [2:0] cleared
  - shifted wdata: `wdata << (addr[2:0]*8)`
  - wstrb: size mask {01,03,0F,FF} << addr[2:0], truncated to 8 bits
- Misaligned means `addr & (bytes-1) != 0`. A misaligned access issues no bus transaction:
  - load: go to RESP with err=1, data=0.
  - store: pulse store_err_o, return to IDLE.
- Load path:
  - RD_ADDR drives m_arvalid with the aligned address.
  - On AR handshake, go to RD_DATA with m_rready=1.
  - On R handshake, capture data = `(m_rdata >> addr[2:0]*8)` masked to the access size, and capture err = (rresp != 0). Then go to RESP.
- Store path:
  - WR raises m_awvalid and m_wvalid together.
  - Each valid drops individually after its own handshake; completions are tracked by aw_done and w_done flags.
  - When both are done, go to WR_RESP with m_bready=1.
  - On B handshake, pulse store_err_o if bresp != 0, then return to IDLE.
- RESP: hold resp_vld/data/err stable until resp_rdy_i, then go to IDLE. Stores never produce resp_vld (the LSU retires stores at request acceptance).
- Timeout:
  - A counter clears on entering RD_ADDR, RD_DATA, WR or WR_RESP, and increments each cycle in those states.
  - When it reaches TIMEOUT, all m_*valid/m_*ready drop.
  - The load completes via RESP with err=1 and data=0; a store pulses store_err_o and returns to IDLE.
  - Late bus responses after a timeout are ignored (ready low).

## Timing
- Reset (all registered): state=IDLE; all m_*valid, m_*ready, resp_vld, resp_err and store_err_o = 0; counters and flags = 0. uncache_mem_ready_o=1 in the first cycle after reset.
- AXI valids are registered. m_arvalid/m_awvalid/m_wvalid rise in the cycle after accept (N+1).
- Zero-wait load: accept N, AR handshake N+1, R handshake N+2, resp_vld at N+3. Minimum load latency is 3 cycles.
- Zero-wait store: accept N, AW+W handshake N+1, B handshake N+2, ready high again at N+3.
- Misaligned load: resp_vld at N+1. Misaligned store: store_err_o at N+1, ready at N+2.
- AW/W handshakes in different cycles are legal; WR exits only after both.
- A simultaneous response handshake and timeout expiry in the same cycle: the handshake wins.
- Reset mid-transaction aborts immediately with no response to the LSU. The interconnect must be reset alongside.
- Ready is combinational from state only; there is no path from uncache_mem_vld_i to ready.

## Structure
- Shared defines file holds:
  - size encodings (UC_SIZE_B/H/W/D)
  - AXI resp codes (OKAY=0, SLVERR=2, DECERR=3)
  - bridge state encoding
- Sub-module `uncache_lane_align`, purely combinational, computes:
  - misaligned flag
  - wstrb
  - shifted wdata
  - right-aligned, size-masked read data
- The top level holds the FSM, timeout counter and AXI registers.

## Test plan
- Load word at 0x1004, rdata=0xAABBCCDD_11223344, zero-wait slave -> araddr=0x1000, resp_data=0x00000000_AABBCCDD, err=0, resp_vld 3 cycles after accept.
- Store byte 0x5A at 0x2003 -> awaddr=0x2000, wstrb=0x08, wdata=0x00000000_5A000000; ready returns 3 cycles after accept.
- Store with W accepted 4 cycles before AW -> single B wait, no duplicate W, bresp=SLVERR gives a 1-cycle store_err_o.
- Load half at 0x3001 -> no m_arvalid, resp_vld next cycle with err=1, data=0.
- TIMEOUT=8, slave never asserts arready -> arvalid drops after 8 cycles, resp err=1; resp_rdy held low 5 cycles keeps data stable.
- Assert rst while in RD_DATA -> next cycle all outputs at reset values, ready=1.
